// File: rtl/tfmc_pkg.sv
// Shared constants for the ticket vending control FSM: state codes, routing codes, coin values, prices.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package tfmc_pkg;

   // State codes S1..S10 map to 0..9
   localparam logic [3:0] S1  = 4'd0;
   localparam logic [3:0] S2  = 4'd1;
   localparam logic [3:0] S3  = 4'd2;
   localparam logic [3:0] S4  = 4'd3;
   localparam logic [3:0] S5  = 4'd4;
   localparam logic [3:0] S6  = 4'd5;
   localparam logic [3:0] S7  = 4'd6;
   localparam logic [3:0] S8  = 4'd7;
   localparam logic [3:0] S9  = 4'd8;
   localparam logic [3:0] S10 = 4'd9;

   // Routing decision reported after the payment comparison
   localparam logic [3:0] RET_MORE   = 4'd1;
   localparam logic [3:0] RET_CHANGE = 4'd6;
   localparam logic [3:0] RET_PRINT  = 4'd7;

   // Coin values in baht
   localparam logic [7:0] COIN_1  = 8'd1;
   localparam logic [7:0] COIN_2  = 8'd2;
   localparam logic [7:0] COIN_5  = 8'd5;
   localparam logic [7:0] COIN_10 = 8'd10;

   // Fare for each destination key
   function automatic logic [7:0] price_of(input logic [2:0] d);
      logic [7:0] p;
      case (d)
         3'd0:    p = 8'd15;
         3'd1:    p = 8'd20;
         3'd2:    p = 8'd25;
         3'd3:    p = 8'd30;
         3'd4:    p = 8'd35;
         3'd5:    p = 8'd40;
         3'd6:    p = 8'd45;
         default: p = 8'd50;
      endcase
      return p;
   endfunction

   // True when exactly one bit is set
   function automatic logic is_onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

   // Index of the set bit of a one-hot byte
   function automatic logic [2:0] onehot_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = i[2:0];
      end
      return idx;
   endfunction

   // Value of a one-hot coin code; zero for anything that is not a single coin
   function automatic logic [7:0] coin_value(input logic [3:0] v);
      logic [7:0] c;
      case (v)
         4'b0001: c = COIN_1;
         4'b0010: c = COIN_2;
         4'b0100: c = COIN_5;
         4'b1000: c = COIN_10;
         default: c = 8'd0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tfmc_price_lut.sv
// Fare lookup: 3-bit destination index to 8-bit price in baht.
// Latency: combinational.
// Backpressure: none.
module tfmc_price_lut
   import tfmc_pkg::*;
(
   input  logic [2:0] dest,
   output logic [7:0] price
);

   assign price = price_of(dest);

endmodule

// File: rtl/ticket_vending_fsm.sv
// Ticket vending control FSM: destination select, coin payment, change, print, pickup wait.
// Latency: one state per clock; state_cmpm is registered and trails each state exit by one cycle.
// Backpressure: none; select/coin/sensor inputs are level-sampled and waited on indefinitely.
// Optional build macro COIN_TIMEOUT_EN: auto-cancel after TIMEOUT_CYCLES idle cycles in the coin state.
module ticket_vending_fsm
   import tfmc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
)
(
   input  logic       clkm,
   input  logic       rstm,
   input  logic       reset_button,
   input  logic       sensor_t,
   input  logic [7:0] DATA_inm,
   output logic       state_cmpm,
   output logic [3:0] return_state
);

   logic [3:0] state;
   logic [2:0] dest;
   logic [7:0] price;
   logic [7:0] paid;
   logic [7:0] coin;
   logic [7:0] change;
   logic       cancel;
   logic       lt;
   logic       gt;
   logic       key_seen;   // a valid destination key is being held
   logic       coin_seen;  // a valid coin is being held

   logic       key_ok;
   logic       coin_ok;
   logic       timeout;
   logic       cancel_req;
   logic [7:0] lut_price;
   logic [8:0] sum9;

   tfmc_price_lut u_price_lut (
      .dest  (dest),
      .price (lut_price)
   );

   assign key_ok     = is_onehot8(DATA_inm);
   assign coin_ok    = (DATA_inm[7:4] == 4'd0) && (coin_value(DATA_inm[3:0]) != 8'd0);
   assign sum9       = {1'b0, paid} + {1'b0, coin};
   assign cancel_req = (state <= S3) && (reset_button || timeout);

`ifdef COIN_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // Count idle cycles in the coin state; any valid coin restarts the count
   always_ff @(posedge clkm) begin
      if (rstm || state != S3 || coin_ok) idle_cnt <= 32'd0;
      else if (!timeout)                  idle_cnt <= idle_cnt + 32'd1;
   end

   assign timeout = (state == S3) && (idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   // Main sequencer: cancel takes priority over any completion in S1..S3
   always_ff @(posedge clkm) begin
      if (rstm) begin
         state        <= S1;
         state_cmpm   <= 1'b0;
         return_state <= 4'd0;
         dest         <= 3'd0;
         price        <= 8'd0;
         paid         <= 8'd0;
         coin         <= 8'd0;
         change       <= 8'd0;
         cancel       <= 1'b0;
         lt           <= 1'b0;
         gt           <= 1'b0;
         key_seen     <= 1'b0;
         coin_seen    <= 1'b0;
      end else begin
         state_cmpm <= 1'b0;
         if (cancel_req) begin
            key_seen  <= 1'b0;
            coin_seen <= 1'b0;
            if (paid == 8'd0) begin
               // Nothing to refund: drop the selection and start over
               state  <= S1;
               dest   <= 3'd0;
               price  <= 8'd0;
               coin   <= 8'd0;
               change <= 8'd0;
               cancel <= 1'b0;
            end else begin
               cancel <= 1'b1;
               state  <= S7;
            end
         end else begin
            case (state)
               S1: begin
                  if (key_ok) begin
                     dest     <= onehot_idx(DATA_inm);
                     key_seen <= 1'b1;
                  end else if (DATA_inm == 8'd0 && key_seen) begin
                     key_seen   <= 1'b0;
                     state      <= S2;
                     state_cmpm <= 1'b1;
                  end
               end
               S2: begin
                  price      <= lut_price;
                  state      <= S3;
                  state_cmpm <= 1'b1;
               end
               S3: begin
                  if (coin_ok) begin
                     coin      <= coin_value(DATA_inm[3:0]);
                     coin_seen <= 1'b1;
                  end else if (DATA_inm == 8'd0 && coin_seen) begin
                     coin_seen  <= 1'b0;
                     state      <= S4;
                     state_cmpm <= 1'b1;
                  end
               end
               S4: begin
                  paid       <= sum9[8] ? 8'hFF : sum9[7:0];
                  state      <= S5;
                  state_cmpm <= 1'b1;
               end
               S5: begin
                  lt         <= paid < price;
                  gt         <= paid > price;
                  state      <= S6;
                  state_cmpm <= 1'b1;
               end
               S6: begin
                  state_cmpm <= 1'b1;
                  if (lt) begin
                     return_state <= RET_MORE;
                     state        <= S2;
                  end else if (gt) begin
                     return_state <= RET_CHANGE;
                     state        <= S7;
                  end else begin
                     return_state <= RET_PRINT;
                     state        <= S8;
                  end
               end
               S7: begin
                  // A cancelled purchase refunds everything and skips printing
                  change     <= cancel ? paid : (paid - price);
                  state      <= cancel ? S10 : S8;
                  state_cmpm <= 1'b1;
               end
               S8: begin
                  state      <= S9;
                  state_cmpm <= 1'b1;
               end
               S9: begin
                  if (sensor_t) begin
                     state      <= S10;
                     state_cmpm <= 1'b1;
                  end
               end
               S10: begin
                  dest       <= 3'd0;
                  price      <= 8'd0;
                  paid       <= 8'd0;
                  coin       <= 8'd0;
                  change     <= 8'd0;
                  cancel     <= 1'b0;
                  state      <= S1;
                  state_cmpm <= 1'b1;
               end
               default: state <= S1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ticket_vending_fsm.sv
// Self-checking bench for ticket_vending_fsm: directed purchases plus randomized ones against a transaction-level model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_ticket_vending_fsm;

   // Spec state encoding S1..S10 = 0..9
   localparam int ST_S1 = 0, ST_S2 = 1, ST_S3 = 2, ST_S4 = 3, ST_S7 = 6,
                  ST_S8 = 7, ST_S9 = 8, ST_S10 = 9;

   logic       clkm = 1'b0;
   logic       rstm;
   logic       reset_button;
   logic       sensor_t;
   logic [7:0] DATA_inm;
   logic       state_cmpm;
   logic [3:0] return_state;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   int plan[$];          // scripted coins for the next purchase; 0 = cancel
   bit junk_next = 1'b0; // force an invalid coin pattern before the next coin
   logic [7:0] junk_pat [3] = '{8'h0C, 8'h30, 8'h13};

   ticket_vending_fsm dut (
      .clkm         (clkm),
      .rstm         (rstm),
      .reset_button (reset_button),
      .sensor_t     (sensor_t),
      .DATA_inm     (DATA_inm),
      .state_cmpm   (state_cmpm),
      .return_state (return_state)
   );

   always #5 clkm = ~clkm;

   // Completion strobes observed on the falling edge
   always @(negedge clkm) if (state_cmpm === 1'b1) pulse_cnt++;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clkm);
      #1;
   endtask

   function automatic int st();
      return int'(dut.state);
   endfunction

   task automatic wait_for(input int s, input string tag);
      for (int i = 0; i < 100 && st() != s; i++) tick();
      chk(tag, st(), s);
   endtask

   task automatic wait_route(output int s);
      int i;
      i = 0;
      while (i < 100 && st() != ST_S2 && st() != ST_S7 && st() != ST_S8) begin
         tick();
         i++;
      end
      s = st();
      if (i >= 100) chk("route_timeout", s, ST_S2);
   endtask

   function automatic logic [7:0] coin_code(input int c);
      case (c)
         1:       return 8'h01;
         2:       return 8'h02;
         5:       return 8'h04;
         default: return 8'h08;
      endcase
   endfunction

   function automatic int pick_coin();
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) return 0;
      if (r <= 2) return 1;
      if (r <= 4) return 2;
      if (r <= 7) return 5;
      return 10;
   endfunction

   // One complete customer session; model tracks paid total and expected strobe count
   task automatic run_tx(input int d);
      int price, paid, exp_pulses, start, coin, s, exp_code, exp_state, hold;
      price      = 15 + 5 * d;
      paid       = 0;
      start      = pulse_cnt;
      exp_pulses = 0;
      chk("tx_idle", st(), ST_S1);
      if ($urandom_range(0, 3) == 0) begin
         DATA_inm = junk_pat[$urandom_range(0, 2)];
         tick();
         DATA_inm = 8'h00;
         tick();
         chk("junk_key_ignored", st(), ST_S1);
      end
      DATA_inm = 8'(1 << d);
      tick();
      DATA_inm = 8'h00;
      tick();
      wait_for(ST_S3, "enter_coin");
      exp_pulses += 2;
      chk("dest", int'(dut.dest), d);
      chk("price", int'(dut.price), price);
      for (int round = 0; round < 80; round++) begin
         if (plan.size() > 0) coin = plan.pop_front();
         else                 coin = pick_coin();
         if (junk_next || $urandom_range(0, 3) == 0) begin
            junk_next = 1'b0;
            start     = start; // keep model untouched: invalid coins change nothing
            DATA_inm  = junk_pat[$urandom_range(0, 2)];
            tick();
            DATA_inm = 8'h00;
            tick();
            chk("junk_coin_ignored", st(), ST_S3);
            chk("junk_coin_no_pulse", pulse_cnt - start, exp_pulses);
         end
         if (coin == 0) begin
            reset_button = 1'b1;
            tick();
            reset_button = 1'b0;
            if (paid == 0) begin
               chk("cancel_empty", st(), ST_S1);
            end else begin
               chk("cancel_refund", st(), ST_S7);
               exp_pulses += 2;
               wait_for(ST_S10, "refund_done");
               chk("refund_change", int'(dut.change), paid);
               wait_for(ST_S1, "refund_idle");
            end
            break;
         end
         DATA_inm = coin_code(coin);
         tick();
         DATA_inm = 8'h00;
         tick();
         paid += coin;
         exp_pulses += 4;
         exp_code  = (paid < price) ? 1 : ((paid > price) ? 6 : 7);
         exp_state = (paid < price) ? ST_S2 : ((paid > price) ? ST_S7 : ST_S8);
         wait_route(s);
         chk("route_code", int'(return_state), exp_code);
         chk("route_state", s, exp_state);
         if (paid < price) begin
            wait_for(ST_S3, "next_coin");
            exp_pulses += 1;
            continue;
         end
         if (paid > price) exp_pulses += 1;
         wait_for(ST_S9, "await_take");
         exp_pulses += 1;
         chk("change", int'(dut.change), (paid > price) ? paid - price : 0);
         hold = int'($urandom_range(0, 3));
         repeat (hold) tick();
         chk("hold_take", st(), ST_S9);
         sensor_t = 1'b1;
         tick();
         sensor_t = 1'b0;
         exp_pulses += 2;
         wait_for(ST_S1, "back_idle");
         break;
      end
      chk("pulse_count", pulse_cnt - start, exp_pulses);
   endtask

   initial begin
      int start;
      rstm         = 1'b1;
      reset_button = 1'b0;
      sensor_t     = 1'b0;
      DATA_inm     = 8'h00;
      tick();
      tick();
      rstm = 1'b0;
      tick();
      chk("reset_state", st(), ST_S1);
      chk("reset_cmpm", int'(state_cmpm), 0);
      chk("reset_ret", int'(return_state), 0);

      // Cancel with nothing paid: stay idle, no strobe
      start        = pulse_cnt;
      reset_button = 1'b1;
      tick();
      reset_button = 1'b0;
      tick();
      chk("s1_cancel_state", st(), ST_S1);
      chk("s1_cancel_no_pulse", pulse_cnt - start, 0);

      plan = '{10, 10, 10};
      run_tx(3);
      plan = '{10, 10};
      run_tx(0);
      plan = '{10, 0};
      run_tx(3);
      junk_next = 1'b1;
      plan = '{10, 10, 5};
      run_tx(2);

      // Reset in the middle of payment
      DATA_inm = 8'h02;
      tick();
      DATA_inm = 8'h00;
      tick();
      wait_for(ST_S3, "rst_enter_coin");
      DATA_inm = 8'h08;
      tick();
      DATA_inm = 8'h00;
      tick();
      chk("rst_in_s4", st(), ST_S4);
      rstm = 1'b1;
      tick();
      rstm = 1'b0;
      chk("mid_rst_state", st(), ST_S1);
      chk("mid_rst_cmpm", int'(state_cmpm), 0);
      chk("mid_rst_ret", int'(return_state), 0);
      chk("mid_rst_paid", int'(dut.paid), 0);
      tick();

      for (int n = 0; n < 25; n++) run_tx(int'($urandom_range(0, 7)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
